// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises core (C) and loader (L) accesses onto one synchronous memory port.
// Optional ARB_ROUND_ROBIN_EN alternates ties between ports; the default build gives the core fixed priority.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_ack,
    output logic [DATA_W-1:0] l_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic [1:0]        state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT - 1);
    localparam logic       PORT_C   = 1'b0;
    localparam logic       PORT_L   = 1'b1;

    logic [1:0]        state_r, state_s;
    logic [1:0]        cnt_r, cnt_s;
    logic              owner_r, owner_s;
    logic              cmd_we_r, cmd_we_s;
    logic [ADDR_W-1:0] cmd_addr_r, cmd_addr_s;
    logic [DATA_W-1:0] cmd_wdata_r, cmd_wdata_s;
    logic              winner_s;

    logic              c_gnt_r, c_gnt_s, l_gnt_r, l_gnt_s;
    logic              c_ack_r, c_ack_s, l_ack_r, l_ack_s;
    logic [DATA_W-1:0] c_rdata_r, c_rdata_s, l_rdata_r, l_rdata_s;
    logic              m_en_r, m_en_s, m_we_r, m_we_s;
    logic              busy_r, busy_s;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_r, last_s;

    // Tie goes to the port that was not granted last
    always_comb begin
        if (c_req && l_req) begin
            winner_s = ~last_r;
        end else if (c_req) begin
            winner_s = PORT_C;
        end else begin
            winner_s = PORT_L;
        end
    end

    // Pointer follows the owner as each access completes
    always_comb begin
        if (state_r == ST_DONE) begin
            last_s = owner_r;
        end else begin
            last_s = last_r;
        end
    end

    // Last-granted pointer; starts at L so the core wins the first tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_r <= PORT_L;
        end else begin
            last_r <= last_s;
        end
    end
`else
    // Fixed priority: loader only wins when the core is not asking
    always_comb begin
        if (c_req) begin
            winner_s = PORT_C;
        end else begin
            winner_s = PORT_L;
        end
    end
`endif

    // Access sequencer: capture command, issue, count latency, complete
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        owner_s     = owner_r;
        cmd_we_s    = cmd_we_r;
        cmd_addr_s  = cmd_addr_r;
        cmd_wdata_s = cmd_wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (c_req || l_req) begin
                    owner_s = winner_s;
                    if (winner_s == PORT_L) begin
                        cmd_we_s    = l_we;
                        cmd_addr_s  = l_addr;
                        cmd_wdata_s = l_wdata;
                    end else begin
                        cmd_we_s    = c_we;
                        cmd_addr_s  = c_addr;
                        cmd_wdata_s = c_wdata;
                    end
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_s   = LAT_LOAD;
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_r == 2'd0) begin
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_r - 2'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle; read data is taken on the last WAIT cycle
    always_comb begin
        m_en_s    = (state_s == ST_ISSUE);
        m_we_s    = (state_s == ST_ISSUE) && cmd_we_s;
        c_gnt_s   = (state_s == ST_ISSUE) && (owner_s == PORT_C);
        l_gnt_s   = (state_s == ST_ISSUE) && (owner_s == PORT_L);
        c_ack_s   = (state_s == ST_DONE) && (owner_s == PORT_C);
        l_ack_s   = (state_s == ST_DONE) && (owner_s == PORT_L);
        busy_s    = (state_s != ST_IDLE);
        c_rdata_s = c_ack_s ? m_rdata : {DATA_W{1'b0}};
        l_rdata_s = l_ack_s ? m_rdata : {DATA_W{1'b0}};
    end

    // State, command and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 2'd0;
            owner_r     <= PORT_C;
            cmd_we_r    <= 1'b0;
            cmd_addr_r  <= {ADDR_W{1'b0}};
            cmd_wdata_r <= {DATA_W{1'b0}};
            m_en_r      <= 1'b0;
            m_we_r      <= 1'b0;
            c_gnt_r     <= 1'b0;
            l_gnt_r     <= 1'b0;
            c_ack_r     <= 1'b0;
            l_ack_r     <= 1'b0;
            busy_r      <= 1'b0;
            c_rdata_r   <= {DATA_W{1'b0}};
            l_rdata_r   <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            owner_r     <= owner_s;
            cmd_we_r    <= cmd_we_s;
            cmd_addr_r  <= cmd_addr_s;
            cmd_wdata_r <= cmd_wdata_s;
            m_en_r      <= m_en_s;
            m_we_r      <= m_we_s;
            c_gnt_r     <= c_gnt_s;
            l_gnt_r     <= l_gnt_s;
            c_ack_r     <= c_ack_s;
            l_ack_r     <= l_ack_s;
            busy_r      <= busy_s;
            c_rdata_r   <= c_rdata_s;
            l_rdata_r   <= l_rdata_s;
        end
    end

    assign c_gnt   = c_gnt_r;
    assign l_gnt   = l_gnt_r;
    assign c_ack   = c_ack_r;
    assign l_ack   = l_ack_r;
    assign c_rdata = c_rdata_r;
    assign l_rdata = l_rdata_r;
    assign m_en    = m_en_r;
    assign m_we    = m_we_r;
    assign m_addr  = cmd_addr_r;
    assign m_wdata = cmd_wdata_r;
    assign busy    = busy_r;
    assign state   = state_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a MEM_LAT=1 instance with a memory model and a MEM_LAT=3 instance.
module tb_mem_arbiter;

    localparam int LAT1 = 1;
    localparam int LAT3 = 3;

    typedef struct packed {
        logic        port;   // 0 = core, 1 = loader
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        chk;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic end_chk = 1'b0;
    logic end_done = 1'b0;

    exp_t gq[$];
    exp_t aq[$];
    exp_t gq3[$];
    exp_t aq3[$];
    exp_t e;

    logic        c_req, c_we, l_req, l_we;
    logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
    logic        c_gnt, c_ack, l_gnt, l_ack, m_en, m_we, busy;
    logic [31:0] c_rdata, l_rdata, m_addr, m_wdata;
    logic [31:0] m_rdata = 32'h0;
    logic [1:0]  state;

    logic        c3_req;
    logic [31:0] c3_addr, m3_rdata;
    logic        c3_gnt, c3_ack, l3_gnt, l3_ack, m3_en, m3_we, busy3;
    logic [31:0] c3_rdata, l3_rdata, m3_addr, m3_wdata;
    logic [1:0]  state3;

    logic [31:0]  mem [0:255];
    logic [255:0] wr_mask = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT1)) u_dut (
        .clk(clk), .reset(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_ack(c_ack), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_ack(l_ack), .l_rdata(l_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .busy(busy), .state(state)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT3)) u_dut3 (
        .clk(clk), .reset(rst_n),
        .c_req(c3_req), .c_we(1'b0), .c_addr(c3_addr), .c_wdata(32'h0),
        .c_gnt(c3_gnt), .c_ack(c3_ack), .c_rdata(c3_rdata),
        .l_req(1'b0), .l_we(1'b0), .l_addr(32'h0), .l_wdata(32'h0),
        .l_gnt(l3_gnt), .l_ack(l3_ack), .l_rdata(l3_rdata),
        .m_en(m3_en), .m_we(m3_we), .m_addr(m3_addr), .m_wdata(m3_wdata), .m_rdata(m3_rdata),
        .busy(busy3), .state(state3)
    );

    function automatic logic [31:0] init_word(input logic [7:0] idx);
        case (idx)
            8'd4:    return 32'hDEADBEEF;
            8'd16:   return 32'hA0A00040;
            8'd17:   return 32'hB1B10044;
            default: return 32'h0;
        endcase
    endfunction

    // Synchronous memory with one cycle of read latency
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) begin
                mem[m_addr[9:2]]     <= m_wdata;
                wr_mask[m_addr[9:2]] <= 1'b1;
            end
            m_rdata <= wr_mask[m_addr[9:2]] ? mem[m_addr[9:2]] : init_word(m_addr[9:2]);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect1(input logic port, input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input logic chk_data, input int gcyc,
                           input logic has_ack);
        gq.push_back('{port, we, addr, data, chk_data, 32'(gcyc)});
        if (has_ack) aq.push_back('{port, we, addr, data, chk_data, 32'(gcyc + 1 + LAT1)});
    endtask

    // Monitor: pops expectations on grant/ack pulses and checks per-cycle invariants
    initial begin : monitor
        int w3;
        logic ack_prev;
        w3 = 0;
        ack_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_ctrl", {c_gnt, c_ack, l_gnt, l_ack, m_en, m_we, busy, state}, 64'd0);
                chk("rst_data", {c_rdata, l_rdata}, 64'd0);
                chk("rst_mem", {m_addr, m_wdata}, 64'd0);
                chk("rst3", {c3_gnt, c3_ack, l3_gnt, l3_ack, m3_en, m3_we, busy3, state3,
                             |c3_rdata, |l3_rdata, |m3_addr, |m3_wdata}, 64'd0);
                ack_prev = 1'b0;
                w3 = 0;
            end else begin
                chk("men_vs_gnt", {63'd0, m_en}, {63'd0, c_gnt | l_gnt});
                chk("mwe_without_men", {63'd0, m_we & ~m_en}, 64'd0);
                chk("busy_vs_state", {63'd0, busy}, {63'd0, state != 2'd0});
                chk("ack_overlap", {63'd0, c_ack & l_ack}, 64'd0);
                if (ack_prev) chk("idle_after_ack", {busy, state}, 64'd0);
                ack_prev = c_ack | l_ack;
                if (c_gnt | l_gnt) begin
                    if (gq.size() == 0) begin
                        chk("unexpected_gnt", {c_gnt, l_gnt}, 64'd0);
                    end else begin
                        e = gq.pop_front();
                        chk("gnt_port", {c_gnt, l_gnt}, e.port ? 64'd1 : 64'd2);
                        chk("gnt_cycle", cyc, e.cyc);
                        chk("gnt_we", m_we, e.we);
                        chk("gnt_addr", m_addr, e.addr);
                        if (e.we) chk("gnt_wdata", m_wdata, e.data);
                    end
                end
                if (c_ack | l_ack) begin
                    if (aq.size() == 0) begin
                        chk("unexpected_ack", {c_ack, l_ack}, 64'd0);
                    end else begin
                        e = aq.pop_front();
                        chk("ack_port", {c_ack, l_ack}, e.port ? 64'd1 : 64'd2);
                        chk("ack_cycle", cyc, e.cyc);
                        if (e.chk) chk("ack_rdata", e.port ? l_rdata : c_rdata, e.data);
                        chk("nonowner_rdata", e.port ? c_rdata : l_rdata, 64'd0);
                    end
                end
                // MEM_LAT=3 instance
                if (state3 == 2'd2) begin
                    w3++;
                end else if (state3 == 2'd3) begin
                    chk("wait3_len", w3, 64'd3);
                    w3 = 0;
                end
                if (c3_gnt | l3_gnt) begin
                    if (gq3.size() == 0) begin
                        chk("unexpected_gnt3", {c3_gnt, l3_gnt}, 64'd0);
                    end else begin
                        e = gq3.pop_front();
                        chk("gnt3_port", {c3_gnt, l3_gnt, m3_en}, 64'd5);
                        chk("gnt3_cycle", cyc, e.cyc);
                        chk("gnt3_addr", m3_addr, e.addr);
                    end
                end
                if (c3_ack | l3_ack) begin
                    if (aq3.size() == 0) begin
                        chk("unexpected_ack3", {c3_ack, l3_ack}, 64'd0);
                    end else begin
                        e = aq3.pop_front();
                        chk("ack3_port", {c3_ack, l3_ack}, 64'd2);
                        chk("ack3_cycle", cyc, e.cyc);
                        chk("ack3_rdata", c3_rdata, e.data);
                        chk("ack3_l_rdata", l3_rdata, 64'd0);
                    end
                end
            end
            if (end_chk && !end_done) begin
                chk("gnt_queue_drained", gq.size(), 64'd0);
                chk("ack_queue_drained", aq.size(), 64'd0);
                chk("gnt3_queue_drained", gq3.size(), 64'd0);
                chk("ack3_queue_drained", aq3.size(), 64'd0);
                end_done = 1'b1;
            end
        end
    end

    // Directed stimulus; every access starts from an IDLE cycle k
    initial begin : stim
        int k;
        rst_n = 1'b1;
        {c_req, c_we, l_req, l_we, c3_req} = 5'b0;
        {c_addr, c_wdata, l_addr, l_wdata, c3_addr} = {5{32'h0}};
        m3_rdata = 32'h0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Both ports requesting: core held for three accesses, loader for four grants' worth
        k = cyc;
        c_req = 1'b1; c_addr = 32'h40;
        l_req = 1'b1; l_addr = 32'h44;
`ifdef ARB_ROUND_ROBIN_EN
        expect1(1'b0, 1'b0, 32'h40, 32'hA0A00040, 1'b1, k + 1, 1'b1);
        expect1(1'b1, 1'b0, 32'h44, 32'hB1B10044, 1'b1, k + 5, 1'b1);
        expect1(1'b0, 1'b0, 32'h40, 32'hA0A00040, 1'b1, k + 9, 1'b1);
        expect1(1'b1, 1'b0, 32'h44, 32'hB1B10044, 1'b1, k + 13, 1'b1);
`else
        expect1(1'b0, 1'b0, 32'h40, 32'hA0A00040, 1'b1, k + 1, 1'b1);
        expect1(1'b0, 1'b0, 32'h40, 32'hA0A00040, 1'b1, k + 5, 1'b1);
        expect1(1'b0, 1'b0, 32'h40, 32'hA0A00040, 1'b1, k + 9, 1'b1);
        expect1(1'b1, 1'b0, 32'h44, 32'hB1B10044, 1'b1, k + 13, 1'b1);
`endif
        wait_to(k + 9);  c_req = 1'b0;
        wait_to(k + 13); l_req = 1'b0;
        wait_to(k + 16);

        // Core read of 0x10
        k = cyc;
        c_req = 1'b1; c_addr = 32'h10;
        expect1(1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, k + 1, 1'b1);
        wait_to(k + 1); c_req = 1'b0;
        wait_to(k + 4);

        // Loader write 0x12345678 to 0x20, then core read back
        k = cyc;
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h20; l_wdata = 32'h12345678;
        expect1(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, k + 1, 1'b1);
        wait_to(k + 1); l_req = 1'b0; l_we = 1'b0;
        wait_to(k + 4);
        c_req = 1'b1; c_addr = 32'h20;
        expect1(1'b0, 1'b0, 32'h20, 32'h12345678, 1'b1, k + 5, 1'b1);
        wait_to(k + 5); c_req = 1'b0;
        wait_to(k + 8);

        // Reset during WAIT of a core read: access abandoned, no ack
        k = cyc;
        c_req = 1'b1; c_addr = 32'h10;
        expect1(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, k + 1, 1'b0);
        wait_to(k + 1); c_req = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        wait_to(k + 3); rst_n = 1'b1;
        wait_to(k + 4);
        c_req = 1'b1; c_addr = 32'h44;
        expect1(1'b0, 1'b0, 32'h44, 32'hB1B10044, 1'b1, k + 5, 1'b1);
        wait_to(k + 5); c_req = 1'b0;
        wait_to(k + 8);

        // MEM_LAT=3: read data changes during WAIT; only the last WAIT value counts
        k = cyc;
        c3_req = 1'b1; c3_addr = 32'h80; m3_rdata = 32'h11111111;
        gq3.push_back('{1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 32'(k + 1)});
        aq3.push_back('{1'b0, 1'b0, 32'h80, 32'hCAFEF00D, 1'b1, 32'(k + 5)});
        wait_to(k + 1); c3_req = 1'b0;
        wait_to(k + 2); m3_rdata = 32'h22222222;
        wait_to(k + 3); m3_rdata = 32'hCAFEF00D;
        wait_to(k + 5); m3_rdata = 32'h55555555;
        wait_to(k + 8);

        end_chk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
